// File: rtl/novacore_cfg_loader.sv
// Configuration frame loader: takes words over a valid/ready stream and
// writes them into the fabric with dimension-switch and c_clk strobes.
module novacore_cfg_loader #(
    parameter int BUS_W   = 28,
    parameter int UID_W   = 4,
    parameter int DIM_W   = 4,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [UID_W-1:0] s_uid,
    input  logic [BUS_W-1:0] s_data,
    input  logic [DIM_W-1:0] s_dim,
    input  logic             s_last,
    output logic             mode,
    output logic [BUS_W-1:0] c_bus,
    output logic [UID_W-1:0] c_uid,
    output logic [DIM_W-1:0] c_dimension,
    output logic             c_clk,
    output logic             c_dimswitch,
    output logic             busy,
    output logic             done,
    output logic [15:0]      word_cnt
);

    typedef enum logic [2:0] {
        IDLE, WAIT, DSW_HI, DSW_LO, SETUP, HIGH, HOLD, DONE
    } state_t;

    state_t     state;
    logic [7:0] phase;
    logic       first;
    logic       last_word;
    logic       phase_end;

    assign phase_end = (phase == 8'(CLK_DIV - 1));

    // Frame sequencer; every output is a register updated on state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= 8'd0;
            first       <= 1'b0;
            last_word   <= 1'b0;
            s_ready     <= 1'b0;
            mode        <= 1'b0;
            c_bus       <= '0;
            c_uid       <= '0;
            c_dimension <= '0;
            c_clk       <= 1'b0;
            c_dimswitch <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_cnt    <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT;
                        mode     <= 1'b1;
                        busy     <= 1'b1;
                        word_cnt <= 16'd0;
                        first    <= 1'b1;
                        s_ready  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (s_valid) begin
                        c_bus       <= s_data;
                        c_uid       <= s_uid;
                        c_dimension <= s_dim;
                        last_word   <= s_last;
                        s_ready     <= 1'b0;
                        first       <= 1'b0;
                        phase       <= 8'd0;
                        // Compare against the dimension still on the bus from the previous word
                        if (first || (s_dim != c_dimension)) begin
                            state       <= DSW_HI;
                            c_dimswitch <= 1'b1;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                DSW_HI: begin
                    if (phase_end) begin
                        phase       <= 8'd0;
                        c_dimswitch <= 1'b0;
                        state       <= DSW_LO;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                DSW_LO: begin
                    if (phase_end) begin
                        phase <= 8'd0;
                        state <= SETUP;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        phase <= 8'd0;
                        c_clk <= 1'b1;
                        state <= HIGH;
                        if (word_cnt != 16'hFFFF) begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase <= 8'd0;
                        c_clk <= 1'b0;
                        state <= HOLD;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        phase <= 8'd0;
                        if (last_word) begin
                            state <= DONE;
                            mode  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Randomized frame-level bench: expected strobe timing is derived from word
// accept times and dimension changes, then compared with observed events.
module tb_novacore_cfg_loader;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
    logic [3:0]  s_uid = 4'd0, s_dim = 4'd0;
    logic [27:0] s_data = 28'd0;
    logic        s_ready, mode, c_clk, c_dimswitch, busy, done;
    logic [27:0] c_bus;
    logic [3:0]  c_uid, c_dimension;
    logic [15:0] word_cnt;

    logic        start1 = 1'b0, s_valid1 = 1'b0;
    logic        s_ready1, mode1, c_clk1, c_dimswitch1, busy1, done1;
    logic [27:0] c_bus1;
    logic [3:0]  c_uid1, c_dimension1;
    logic [15:0] word_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    novacore_cfg_loader #(.BUS_W(28), .UID_W(4), .DIM_W(4), .CLK_DIV(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_uid(s_uid), .s_data(s_data), .s_dim(s_dim), .s_last(s_last), .mode(mode),
        .c_bus(c_bus), .c_uid(c_uid), .c_dimension(c_dimension), .c_clk(c_clk),
        .c_dimswitch(c_dimswitch), .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    novacore_cfg_loader #(.BUS_W(28), .UID_W(4), .DIM_W(4), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_uid(4'd9), .s_data(28'h1234567), .s_dim(4'd5), .s_last(1'b1), .mode(mode1),
        .c_bus(c_bus1), .c_uid(c_uid1), .c_dimension(c_dimension1), .c_clk(c_clk1),
        .c_dimswitch(c_dimswitch1), .busy(busy1), .done(done1), .word_cnt(word_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor for the CLK_DIV=2 instance
    int          acc_q[$];
    int          rise_q[$];
    logic [27:0] rise_bus[$];
    logic [3:0]  rise_uid[$], rise_dim[$], dsw_dim[$];
    int          dsw_q[$];
    int          clk_hi_n, dsw_hi_n, overlap_n, mode_bad_n, done_cyc;
    bit          prev_clk, prev_dsw;

    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            acc_q.push_back(cyc);
            if (!mode || !busy) mode_bad_n++;
        end
        if (c_clk && !prev_clk) begin
            rise_q.push_back(cyc); rise_bus.push_back(c_bus);
            rise_uid.push_back(c_uid); rise_dim.push_back(c_dimension);
        end
        if (c_dimswitch && !prev_dsw) begin
            dsw_q.push_back(cyc); dsw_dim.push_back(c_dimension);
        end
        if (c_clk) clk_hi_n++;
        if (c_dimswitch) dsw_hi_n++;
        if (c_clk && c_dimswitch) overlap_n++;
        if (done) done_cyc = cyc;
        prev_clk = c_clk;
        prev_dsw = c_dimswitch;
    end

    task automatic clear_mon();
        acc_q.delete(); rise_q.delete(); rise_bus.delete(); rise_uid.delete();
        rise_dim.delete(); dsw_q.delete(); dsw_dim.delete();
        clk_hi_n = 0; dsw_hi_n = 0; overlap_n = 0; mode_bad_n = 0; done_cyc = -1;
    endtask

    // dim_mode: 0 random small dims, 1 all dim 2, 2 dims 1 then 4, 3 fixed reference word
    task automatic run_frame(input string name, input int n, input int max_gap, input int dim_mode);
        logic [27:0] wd[16];
        logic [3:0]  wu[16], wm[16];
        int          gap[16], exp_a[16], exp_rise[16];
        bit          sw[16];
        int          s, v, rdy, nsw, k, tmo;
        int          exp_dsw[$];
        for (int i = 0; i < n; i++) begin
            wd[i]  = 28'($urandom);
            wu[i]  = 4'($urandom);
            gap[i] = $urandom_range(0, max_gap);
            case (dim_mode)
                1: wm[i] = 4'd2;
                2: wm[i] = (i == 0) ? 4'd1 : 4'd4;
                3: begin wm[i] = 4'd1; wd[i] = 28'h0ABCDEF; wu[i] = 4'd3; end
                default: wm[i] = 4'($urandom_range(0, 2));
            endcase
        end
        clear_mon();
        @(posedge clk); #1; start = 1'b1; s = cyc;
        @(posedge clk); #1; start = 1'b0;
        // reference timing from frame rules
        rdy = s + 1; nsw = 0;
        for (int i = 0; i < n; i++) begin
            v = (i == 0) ? s + 1 + gap[0] : exp_a[i-1] + 1 + gap[i];
            exp_a[i] = (v > rdy) ? v : rdy;
            sw[i] = (i == 0) || (wm[i] != wm[i-1]);
            if (sw[i]) begin nsw++; exp_dsw.push_back(exp_a[i] + 1); end
            exp_rise[i] = exp_a[i] + 1 + D + (sw[i] ? 2*D : 0);
            rdy = exp_a[i] + 1 + 3*D + (sw[i] ? 2*D : 0);
        end
        for (int i = 0; i < n; i++) begin
            if (gap[i] > 0) begin repeat (gap[i]) @(posedge clk); #1; end
            s_valid = 1'b1; s_data = wd[i]; s_uid = wu[i]; s_dim = wm[i]; s_last = (i == n-1);
            tmo = 0;
            while (tmo < 300) begin
                @(negedge clk);
                if (s_ready) break;
                tmo++;
            end
            @(posedge clk); #1; s_valid = 1'b0;
            if (tmo >= 300) begin
                errors++; checks++;
                $display("FAIL %s accept_timeout word %0d", name, i);
                return;
            end
        end
        tmo = 0;
        while (!done && tmo < 300) begin @(negedge clk); tmo++; end
        @(posedge clk); #1;
        checks++;
        if (acc_q.size() != n || rise_q.size() != n || dsw_q.size() != nsw) begin
            errors++;
            $display("FAIL %s event_counts acc=%0d rise=%0d dsw=%0d expected %0d/%0d/%0d",
                     name, acc_q.size(), rise_q.size(), dsw_q.size(), n, n, nsw);
            return;
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (acc_q[i] !== exp_a[i]) begin
                errors++; $display("FAIL %s accept_time[%0d] got %0d expected %0d", name, i, acc_q[i] - s, exp_a[i] - s);
            end
            checks++;
            if (rise_q[i] !== exp_rise[i] || rise_bus[i] !== wd[i] || rise_uid[i] !== wu[i] || rise_dim[i] !== wm[i]) begin
                errors++;
                $display("FAIL %s c_clk_rise[%0d] got t=%0d bus=%h uid=%0d dim=%0d expected t=%0d bus=%h uid=%0d dim=%0d",
                         name, i, rise_q[i] - s, rise_bus[i], rise_uid[i], rise_dim[i], exp_rise[i] - s, wd[i], wu[i], wm[i]);
            end
        end
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (sw[i]) begin
                checks++;
                if (dsw_q[k] !== exp_dsw[k] || dsw_dim[k] !== wm[i]) begin
                    errors++;
                    $display("FAIL %s dimswitch[%0d] got t=%0d dim=%0d expected t=%0d dim=%0d",
                             name, k, dsw_q[k] - s, dsw_dim[k], exp_dsw[k] - s, wm[i]);
                end
                k++;
            end
        end
        checks++;
        if (clk_hi_n !== n*D || dsw_hi_n !== nsw*D || overlap_n !== 0 || mode_bad_n !== 0) begin
            errors++;
            $display("FAIL %s strobe_widths clk_hi=%0d dsw_hi=%0d overlap=%0d mode_bad=%0d expected %0d/%0d/0/0",
                     name, clk_hi_n, dsw_hi_n, overlap_n, mode_bad_n, n*D, nsw*D);
        end
        checks++;
        if (done_cyc !== rdy) begin
            errors++; $display("FAIL %s done_time got %0d expected %0d", name, done_cyc - s, rdy - s);
        end
        checks++;
        if (word_cnt !== 16'(n) || mode !== 1'b0 || busy !== 1'b0 || c_bus !== wd[n-1] || c_dimension !== wm[n-1]) begin
            errors++;
            $display("FAIL %s end_state word_cnt=%0d mode=%b busy=%b bus=%h dim=%0d expected %0d/0/0/%h/%0d",
                     name, word_cnt, mode, busy, c_bus, c_dimension, n, wd[n-1], wm[n-1]);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({mode, c_clk, c_dimswitch, s_ready, busy, done} !== 6'b0 || c_bus !== 28'd0 ||
            c_uid !== 4'd0 || c_dimension !== 4'd0 || word_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_values got mode=%b ready=%b busy=%b bus=%h cnt=%0d expected all zero",
                               mode, s_ready, busy, c_bus, word_cnt);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_stall();
        int bad = 0, tmo = 0;
        clear_mon();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 8 || i == 14);
            @(negedge clk);
            if (!s_ready || !mode || c_clk || c_dimswitch) bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stall_idle bad_cycles=%0d expected 0", bad); end
        s_valid = 1'b1; s_data = 28'h5A5A5A5; s_uid = 4'd7; s_dim = 4'd6; s_last = 1'b1;
        @(posedge clk); #1; s_valid = 1'b0;
        while (!done && tmo < 100) begin @(negedge clk); tmo++; end
        checks++;
        if (!done || word_cnt !== 16'd1 || dsw_hi_n !== D || clk_hi_n !== D) begin
            errors++; $display("FAIL stall_complete done=%b cnt=%0d dsw_hi=%0d clk_hi=%0d expected 1/1/%0d/%0d",
                               done, word_cnt, dsw_hi_n, clk_hi_n, D, D);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int tmo = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        s_valid = 1'b1; s_data = 28'hFEDCBA9; s_uid = 4'd2; s_dim = 4'd3; s_last = 1'b0;
        @(posedge clk); #1; s_valid = 1'b0;
        while (!c_clk && tmo < 100) begin @(negedge clk); tmo++; end
        #1; rst = 1'b1; #1;
        checks++;
        if (tmo >= 100 || c_clk !== 1'b0 || c_dimswitch !== 1'b0 || mode !== 1'b0 || c_bus !== 28'd0 ||
            c_uid !== 4'd0 || c_dimension !== 4'd0 || word_cnt !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid c_clk=%b mode=%b bus=%h cnt=%0d busy=%b expected all zero",
                               c_clk, mode, c_bus, word_cnt, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mode !== 1'b0 || s_ready !== 1'b0 || c_clk !== 1'b0 || c_dimswitch !== 1'b0) begin
            errors++; $display("FAIL reset_quiet mode=%b ready=%b c_clk=%b dsw=%b expected 0", mode, s_ready, c_clk, c_dimswitch);
        end
    endtask

    task automatic test_clkdiv1();
        int acc = -1, dc = -1, hi = 0, tmo = 0;
        @(posedge clk); #1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0; s_valid1 = 1'b1;
        @(negedge clk);
        if (s_ready1) acc = cyc;
        @(posedge clk); #1; s_valid1 = 1'b0;
        while (tmo < 50) begin
            @(negedge clk);
            if (c_clk1) hi++;
            if (done1) begin dc = cyc; break; end
            tmo++;
        end
        checks++;
        if (acc < 0 || hi !== 1 || (dc - acc) !== 6 || word_cnt1 !== 16'd1 || c_bus1 !== 28'h1234567) begin
            errors++; $display("FAIL clkdiv1 c_clk_hi=%0d accept_to_done=%0d cnt=%0d bus=%h expected 1/6/1/1234567",
                               hi, dc - acc, word_cnt1, c_bus1);
        end
    endtask

    initial begin
        test_reset();
        run_frame("single_word", 1, 0, 3);
        run_frame("same_dim", 2, 0, 1);
        run_frame("dim_change", 2, 0, 2);
        test_stall();
        test_reset_mid();
        run_frame("after_reset", 1, 0, 3);
        for (int f = 0; f < 8; f++) run_frame("random", $urandom_range(1, 6), 3, 0);
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
